// File: rtl/ds1302_pkg.sv
// ds1302_pkg: register map, command-byte field positions, FSM states and
// a BCD increment helper shared by the DS1302 responder.
package ds1302_pkg;

  localparam logic [4:0] ADDR_SEC   = 5'd0;
  localparam logic [4:0] ADDR_MIN   = 5'd1;
  localparam logic [4:0] ADDR_HOUR  = 5'd2;
  localparam logic [4:0] ADDR_DATE  = 5'd3;
  localparam logic [4:0] ADDR_MONTH = 5'd4;
  localparam logic [4:0] ADDR_WEEK  = 5'd5;
  localparam logic [4:0] ADDR_YEAR  = 5'd6;
  localparam logic [4:0] ADDR_WP    = 5'd7;
  localparam logic [4:0] ADDR_BURST = 5'd31;

  localparam int unsigned CMD_RD_BIT    = 0;
  localparam int unsigned CMD_ADDR_LSB  = 1;
  localparam int unsigned CMD_ADDR_MSB  = 5;
  localparam int unsigned CMD_RAM_BIT   = 6;
  localparam int unsigned CMD_VALID_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_HOLD
  } state_e;

  // Packed-BCD +1 without range wrap; callers handle their own rollover value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/ds1302_slave_sync.sv
// ds1302_slave_sync: multi-stage synchronisers for ce/sclk/io and one-clk
// rise/fall pulses derived from the synchronised sclk.
module ds1302_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic sclk_i,
  input  logic io_i,
  output logic ce_o,
  output logic io_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  logic [SYNC_STAGES-1:0] ce_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] io_q;
  logic                   sclk_prev_q;

  // Shift the raw pad levels through the synchroniser chains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ce_q        <= '0;
      sclk_q      <= '0;
      io_q        <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      ce_q        <= {ce_q[SYNC_STAGES-2:0], ce_i};
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      io_q        <= {io_q[SYNC_STAGES-2:0], io_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign ce_o        = ce_q[SYNC_STAGES-1];
  assign io_o        = io_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/ds1302_slave.sv
// ds1302_slave: DS1302 3-wire RTC responder holding the seven clock registers
// and the write-protect bit. Define DS1302_SLAVE_TICK_EN to let tick_1hz
// advance the time registers in BCD.
module ds1302_slave
  import ds1302_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        WP_RESET    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  input  logic       ds1302_io_in,
  output logic       ds1302_io_out,
  output logic       ds1302_io_oe,
  input  logic       tick_1hz,
  output logic [7:0] reg_second,
  output logic [7:0] reg_minute,
  output logic [7:0] reg_hour,
  output logic [7:0] reg_date,
  output logic [7:0] reg_month,
  output logic [7:0] reg_week,
  output logic [7:0] reg_year,
  output logic       reg_wp,
  output logic       wr_pulse,
  output logic       rd_pulse,
  output logic [4:0] cmd_addr
);

  logic       ce_s, io_s, sclk_rise, sclk_fall;
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       io_out_q, io_out_d;
  logic       io_oe_q, io_oe_d;
  logic       commit_q, commit_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic       rd_pulse_q, rd_pulse_d;
  logic [4:0] cmd_addr_q, cmd_addr_d;
  logic       wvalid_q, wvalid_d;
  logic [7:0] rtc_q [7];
  logic [7:0] rtc_d [7];
  logic       wp_q, wp_d;
  logic [7:0] shift_in;
  logic [4:0] in_addr;
  logic [7:0] rd_value;

  ds1302_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk),
    .rst_i       (rst),
    .ce_i        (ds1302_ce),
    .sclk_i      (ds1302_sclk),
    .io_i        (ds1302_io_in),
    .ce_o        (ce_s),
    .io_o        (io_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall)
  );

  // Byte as it will look once the current io bit is shifted in (LSB first).
  assign shift_in = {io_s, shift_q[7:1]};
  assign in_addr  = shift_in[CMD_ADDR_MSB:CMD_ADDR_LSB];

  // Read data for the command byte being decoded; RAM/burst/unused addresses read 0.
  always_comb begin
    rd_value = '0;
    if (!shift_in[CMD_RAM_BIT]) begin
      if (in_addr == ADDR_WP)     rd_value = {wp_q, 7'b0};
      else if (in_addr < ADDR_WP) rd_value = rtc_q[in_addr[2:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a low ce overrides everything.
  always_comb begin
    state_d = state_q;
    if (!ce_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_CMD;
        S_CMD:   if (sclk_rise && bitcnt_q == 3'd7) begin
                   if (!shift_in[CMD_VALID_BIT])  state_d = S_HOLD;
                   else if (shift_in[CMD_RD_BIT]) state_d = S_RDATA;
                   else                           state_d = S_WDATA;
                 end
        S_WDATA: if (sclk_rise && bitcnt_q == 3'd7) state_d = S_HOLD;
        S_RDATA: if (sclk_fall && bitcnt_q == 3'd7) state_d = S_HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs and serial datapath next values.
  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    rdata_d    = rdata_q;
    io_out_d   = io_out_q;
    io_oe_d    = io_oe_q;
    commit_d   = 1'b0;
    wr_pulse_d = commit_q;
    rd_pulse_d = 1'b0;
    cmd_addr_d = cmd_addr_q;
    wvalid_d   = wvalid_q;
    if (!ce_s) begin
      shift_d  = '0;
      bitcnt_d = '0;
      io_oe_d  = 1'b0;
      io_out_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  bitcnt_d = '0;
        S_CMD:   if (sclk_rise) begin
                   shift_d  = shift_in;
                   bitcnt_d = bitcnt_q + 3'd1;
                   if (bitcnt_q == 3'd7 && shift_in[CMD_VALID_BIT]) begin
                     cmd_addr_d = in_addr;
                     wvalid_d   = !shift_in[CMD_RAM_BIT] && (in_addr <= ADDR_WP);
                     rdata_d    = rd_value;
                     rd_pulse_d = shift_in[CMD_RD_BIT];
                   end
                 end
        S_WDATA: if (sclk_rise) begin
                   shift_d  = shift_in;
                   bitcnt_d = bitcnt_q + 3'd1;
                   if (bitcnt_q == 3'd7)
                     commit_d = wvalid_q && (cmd_addr_q == ADDR_WP || !wp_q);
                 end
        S_RDATA: if (sclk_fall) begin
                   io_oe_d  = 1'b1;
                   io_out_d = rdata_q[0];
                   rdata_d  = {1'b0, rdata_q[7:1]};
                   bitcnt_d = bitcnt_q + 3'd1;
                 end
        default: ;
      endcase
    end
  end

  // Serial datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bitcnt_q   <= '0;
      rdata_q    <= '0;
      io_out_q   <= 1'b0;
      io_oe_q    <= 1'b0;
      commit_q   <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      cmd_addr_q <= '0;
      wvalid_q   <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      rdata_q    <= rdata_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      commit_q   <= commit_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      cmd_addr_q <= cmd_addr_d;
      wvalid_q   <= wvalid_d;
    end
  end

`ifndef DS1302_SLAVE_TICK_EN
  logic unused_tick;
  assign unused_tick = tick_1hz;
`endif

  // Register file next values: time advance first, then a committing write
  // overrides its own target while carries into other registers still land.
  always_comb begin
    rtc_d = rtc_q;
    wp_d  = wp_q;
`ifdef DS1302_SLAVE_TICK_EN
    if (tick_1hz && !rtc_q[0][7]) begin
      if (rtc_q[0] == 8'h59) begin
        rtc_d[0] = 8'h00;
        if (rtc_q[1] == 8'h59) begin
          rtc_d[1] = 8'h00;
          if (rtc_q[2] == 8'h23) begin
            rtc_d[2] = 8'h00;
            rtc_d[3] = (rtc_q[3] == 8'h31) ? 8'h01 : bcd_inc(rtc_q[3]);
            rtc_d[5] = (rtc_q[5] == 8'h07) ? 8'h01 : bcd_inc(rtc_q[5]);
          end else begin
            rtc_d[2] = bcd_inc(rtc_q[2]);
          end
        end else begin
          rtc_d[1] = bcd_inc(rtc_q[1]);
        end
      end else begin
        rtc_d[0] = bcd_inc(rtc_q[0]);
      end
    end
`endif
    if (commit_q) begin
      if (cmd_addr_q == ADDR_WP) wp_d = shift_q[7];
      else                       rtc_d[cmd_addr_q[2:0]] = shift_q;
    end
  end

  // Register file storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 7; i++) rtc_q[i] <= '0;
      wp_q <= WP_RESET;
    end else begin
      rtc_q <= rtc_d;
      wp_q  <= wp_d;
    end
  end

  assign ds1302_io_out = io_out_q;
  assign ds1302_io_oe  = io_oe_q;
  assign reg_second    = rtc_q[0];
  assign reg_minute    = rtc_q[1];
  assign reg_hour      = rtc_q[2];
  assign reg_date      = rtc_q[3];
  assign reg_month     = rtc_q[4];
  assign reg_week      = rtc_q[5];
  assign reg_year      = rtc_q[6];
  assign reg_wp        = wp_q;
  assign wr_pulse      = wr_pulse_q;
  assign rd_pulse      = rd_pulse_q;
  assign cmd_addr      = cmd_addr_q;

endmodule

// File: tb/tb_ds1302_slave.sv
// tb_ds1302_slave: directed-vector bench for the DS1302 responder, acting as
// the serial master and checking registers, pulses and read-back data.
`timescale 1ns/1ps
module tb_ds1302_slave;

  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       sclk = 1'b0;
  logic       io_in = 1'b0;
  logic       tick = 1'b0;
  logic       io_out, io_oe;
  logic [7:0] reg_second, reg_minute, reg_hour, reg_date, reg_month, reg_week, reg_year;
  logic       reg_wp, wr_pulse, rd_pulse;
  logic [4:0] cmd_addr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned wr_cnt  = 0;
  int unsigned rd_cnt  = 0;

  logic [7:0] rdat;
  logic       oe_pre, oe_first, oe_hold;

  ds1302_slave #(.SYNC_STAGES(2), .WP_RESET(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ds1302_ce     (ce),
    .ds1302_sclk   (sclk),
    .ds1302_io_in  (io_in),
    .ds1302_io_out (io_out),
    .ds1302_io_oe  (io_oe),
    .tick_1hz      (tick),
    .reg_second    (reg_second),
    .reg_minute    (reg_minute),
    .reg_hour      (reg_hour),
    .reg_date      (reg_date),
    .reg_month     (reg_month),
    .reg_week      (reg_week),
    .reg_year      (reg_year),
    .reg_wp        (reg_wp),
    .wr_pulse      (wr_pulse),
    .rd_pulse      (rd_pulse),
    .cmd_addr      (cmd_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (rd_pulse) rd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic waitc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    io_in = b;
    waitc(HALF);
    sclk = 1'b1;
    waitc(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic wr_txn(input logic [7:0] c, input logic [7:0] d);
    ce = 1'b1;
    waitc(HALF);
    send_byte(c);
    send_byte(d);
    waitc(HALF);
    ce = 1'b0;
    waitc(HALF);
  endtask

  task automatic rd_txn(input logic [7:0] c, output logic [7:0] data,
                        output logic pre, output logic first, output logic hold);
    ce = 1'b1;
    waitc(HALF);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    io_in = c[7];
    waitc(HALF);
    sclk = 1'b1;
    waitc(HALF);
    pre  = io_oe;
    sclk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waitc(HALF);
      if (i == 0) first = io_oe;
      data[i] = io_out;
      sclk = 1'b1;
      waitc(HALF);
      sclk = 1'b0;
    end
    waitc(HALF);
    hold = io_oe;
    ce = 1'b0;
    waitc(HALF);
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    waitc(1);
    tick = 1'b0;
    waitc(2);
  endtask

  initial begin
    waitc(4);
    rst = 1'b0;
    waitc(2);
    check("rst_regs", {reg_second, reg_minute, reg_hour, reg_date, reg_month, reg_week, reg_year}, 64'h0);
    check("rst_wp", reg_wp, 1'b1);
    check("rst_io", {io_oe, io_out}, 2'b00);
    check("rst_pulses", {wr_pulse, rd_pulse}, 2'b00);
    check("rst_cmd_addr", cmd_addr, 5'd0);

    // write-protected second write is dropped
    wr_txn(8'h80, 8'h45);
    check("wp_block_pulse", wr_cnt, 0);
    check("wp_block_sec", reg_second, 8'h00);

    wr_txn(8'h8E, 8'h00);
    check("wp_clear", reg_wp, 1'b0);
    check("wp_clear_pulse", wr_cnt, 1);
    wr_txn(8'h80, 8'h45);
    check("sec_write", reg_second, 8'h45);
    check("sec_write_pulse", wr_cnt, 2);

    // register read of minute
    wr_txn(8'h82, 8'h59);
    check("min_write", reg_minute, 8'h59);
    rd_txn(8'h83, rdat, oe_pre, oe_first, oe_hold);
    check("min_rd_data", rdat, 8'h59);
    check("min_rd_oe_pre", oe_pre, 1'b0);
    check("min_rd_oe_first", oe_first, 1'b1);
    check("min_rd_oe_hold", oe_hold, 1'b1);
    check("min_rd_pulse", rd_cnt, 1);
    check("min_rd_addr", cmd_addr, 5'd1);
    check("min_rd_oe_after", io_oe, 1'b0);

    // abort mid-write of hour
    wr_txn(8'h84, 8'h08);
    check("hour_write", reg_hour, 8'h08);
    ce = 1'b1;
    waitc(HALF);
    send_byte(8'h84);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    waitc(HALF);
    ce = 1'b0;
    waitc(HALF);
    check("abort_hour", reg_hour, 8'h08);
    check("abort_oe", io_oe, 1'b0);
    check("abort_pulse", wr_cnt, 4);
    rd_txn(8'h85, rdat, oe_pre, oe_first, oe_hold);
    check("abort_next_rd", rdat, 8'h08);
    check("abort_next_pulse", rd_cnt, 2);

    // invalid commands
    wr_txn(8'h00, 8'h99);
    check("bit7_wr_sec", reg_second, 8'h45);
    check("bit7_wr_pulse", wr_cnt, 4);
    rd_txn(8'h01, rdat, oe_pre, oe_first, oe_hold);
    check("bit7_rd_oe", {oe_first, oe_hold}, 2'b00);
    check("bit7_rd_pulse", rd_cnt, 2);
    rd_txn(8'hC1, rdat, oe_pre, oe_first, oe_hold);
    check("ram_rd_data", rdat, 8'h00);
    check("ram_rd_oe", oe_first, 1'b1);
    check("ram_rd_pulse", rd_cnt, 3);
    wr_txn(8'h90, 8'h77);
    check("addr8_cmd_addr", cmd_addr, 5'd8);
    check("addr8_pulse", wr_cnt, 4);
    wr_txn(8'hBE, 8'h11);
    check("burst_cmd_addr", cmd_addr, 5'd31);
    check("burst_pulse", wr_cnt, 4);

    // WP read-back, then write-protected register write
    wr_txn(8'h8E, 8'h80);
    check("wp_set", reg_wp, 1'b1);
    rd_txn(8'h8F, rdat, oe_pre, oe_first, oe_hold);
    check("wp_rd_data", rdat, 8'h80);
    check("wp_rd_addr", cmd_addr, 5'd7);
    wr_txn(8'h82, 8'h33);
    check("wp_block_min", reg_minute, 8'h59);
    wr_txn(8'h8E, 8'h00);
    check("wp_clear2", reg_wp, 1'b0);
    check("wr_pulse_total", wr_cnt, 6);

`ifdef DS1302_SLAVE_TICK_EN
    wr_txn(8'h80, 8'h59);
    wr_txn(8'h82, 8'h59);
    wr_txn(8'h84, 8'h23);
    wr_txn(8'h86, 8'h31);
    wr_txn(8'h8A, 8'h07);
    pulse_tick;
    check("tick_time", {reg_hour, reg_minute, reg_second}, 24'h000000);
    check("tick_date", reg_date, 8'h01);
    check("tick_week", reg_week, 8'h01);
    check("tick_month", reg_month, 8'h00);
    wr_txn(8'h80, 8'h80);
    pulse_tick;
    check("tick_ch_sec", reg_second, 8'h80);
    check("tick_ch_min", reg_minute, 8'h00);
`else
    pulse_tick;
    check("tick_ignored", reg_second, 8'h45);
`endif

    // reset while presenting read data
    ce = 1'b1;
    waitc(HALF);
    send_byte(8'h83);
    waitc(HALF);
    check("rstrd_oe_pre", io_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("rstrd_oe", io_oe, 1'b0);
    check("rstrd_regs", {reg_second, reg_minute, reg_hour, reg_date, reg_month, reg_week, reg_year}, 64'h0);
    check("rstrd_wp", reg_wp, 1'b1);
    check("rstrd_addr", cmd_addr, 5'd0);
    ce = 1'b0;
    sclk = 1'b0;
    waitc(4);
    rst = 1'b0;
    waitc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
